sent_tx_pulse_gen: RTL
======================

Name: sent_tx_pulse_gen

Overview:
- Converts the SENT TX controller's per-period commands (sync, pause, data nibble) into the SENT line waveform, timed in ticks derived from clk_tx.
- Each period is a fixed-width low pulse followed by a high phase. The total period length encodes the command.
- Asserts pulse_done during the final tick of every period. Its falling edge is the period boundary the controller uses to advance its FSM.
- Sits directly downstream of the TX control FSM and drives the SENT output pin.

Parameters:
TICK_DIV, 3, clk_tx cycles per SENT tick; legal range 2..255; TICK_DIV*LOW_TICKS must be >= 4.
LOW_TICKS, 5, ticks the line is held low at the start of every period.
SYNC_TICKS, 56, total ticks of a sync period.
NIB_BASE, 12, ticks of a nibble period for nibble value 0; a nibble period is NIB_BASE+value ticks.
PAUSE_MIN, 12, lower clamp for the pause period length in ticks.
PAUSE_MAX, 768, upper clamp for the pause period length in ticks.

Ports:
clk_tx  in  1  single clock; all logic on the rising edge
reset_tx  in  1  asynchronous, active-high reset
sync  in  1  command: next period is a sync pulse
pause  in  1  command: next period is a pause pulse
pulse  in  1  command: next period is a data/status/CRC nibble
idle  in  1  controller has finished its frame set; stop after the current period
data_nibble  in  4  nibble value for a pulse command
pause_len  in  10  requested pause length in ticks, clamped to PAUSE_MIN..PAUSE_MAX
sent_out  out  1  SENT line; 1 = recessive/high
pulse_done  out  1  high during the final tick of each period
busy  out  1  high whenever the block is not in IDLE
cmd_err  out  1  one-clock strobe: more than one command, or none, at the sample point

Behaviour:
- Reset (async, any time, including mid-period): state=IDLE, prescaler=0, tick_cnt=0, period_len=0, sent_out=1, pulse_done=0, busy=0, cmd_err=0.
- Prescaler div_cnt counts 0..TICK_DIV-1 and wraps; tick_end = (div_cnt==TICK_DIV-1). It is cleared on every period start.
- tick_cnt holds completed ticks in the current period and increments on tick_end.
- Command present: cmd_any = (sync|pause|pulse) & !idle.
- States: IDLE, LOW, HIGH.
- IDLE:
  - Outputs: sent_out=1, pulse_done=0, busy=0.
  - If cmd_any: next edge enters LOW with tick_cnt=0 and div_cnt=0.
- LOW:
  - Outputs: sent_out=0, busy=1.
  - On the clock where tick_cnt==LOW_TICKS-1 and tick_end (the last clock of the low phase), sample the command and load period_len:
    - sync: SYNC_TICKS.
    - else pause: clamp(pause_len).
    - else pulse: NIB_BASE+data_nibble, zero-extended to 10 bits.
    - none asserted: NIB_BASE, and cmd_err=1.
  - Priority is sync > pause > pulse. If two or more are asserted, cmd_err=1 for that clock.
  - The same edge enters HIGH.
- HIGH:
  - Outputs: sent_out=1, busy=1.
  - pulse_done=1 while tick_cnt==period_len-1, for exactly TICK_DIV clocks.
  - On tick_end with tick_cnt==period_len-1 (period end):
    - If cmd_any: enter LOW with tick_cnt=0, div_cnt=0, pulse_done=0.
    - Else: enter IDLE, pulse_done=0.
- Clamp rule: pause_len<PAUSE_MIN gives PAUSE_MIN; pause_len>PAUSE_MAX gives PAUSE_MAX. Compare in 10 bits.
- Timing:
  - Period length in clocks = period_len*TICK_DIV exactly. Back-to-back periods have no gap cycles.
  - pulse_done falls on the same edge that sent_out falls for the next period.
  - The command is sampled TICK_DIV*LOW_TICKS-1 clocks after the period starts. This latency lets the controller update data_nibble after seeing the falling edge of pulse_done.
- Command changes outside the sample clock are ignored. period_len is held for the rest of the period.
- idle asserted mid-period: the current period completes normally, then the block enters IDLE.
- Commands asserted in IDLE: LOW starts on the next edge, which is a 1-clock start latency.

Test Plan:
- TICK_DIV=3, pulse=1, data_nibble=0 -> sent_out low for 15 clocks, high for 21 (period 36 clocks); pulse_done high for the last 3 clocks; busy=1 throughout.
- pulse with data_nibble=15, then sync on the next period -> periods of 81 clocks then 168 clocks; no gap between them; pulse_done falling edge coincident with each sent_out falling edge.
- pause=1 with pause_len=5, then 1000, then 300 -> periods of 36, 2304 and 900 clocks respectively (clamp verified).
- sync=1 and pulse=1 together at the sample point -> 56-tick period; cmd_err=1 for exactly 1 clock. All commands low at the sample point -> 12-tick period and cmd_err=1.
- data_nibble changed from 3 to 9 during the low phase but before the sample clock -> period = 21 ticks. Changed after the sample clock -> period stays 21 ticks.
- reset_tx asserted mid-HIGH -> sent_out=1, pulse_done=0, busy=0 immediately (async). idle=1 at a period end -> return to IDLE with sent_out held at 1.

Source files
------------

// File: rtl/sent_tx_pulse_gen.sv
// sent_tx_pulse_gen: turns per-period SENT commands into the tick-timed line waveform
module sent_tx_pulse_gen #(
    parameter int TICK_DIV   = 3,
    parameter int LOW_TICKS  = 5,
    parameter int SYNC_TICKS = 56,
    parameter int NIB_BASE   = 12,
    parameter int PAUSE_MIN  = 12,
    parameter int PAUSE_MAX  = 768
) (
    input  logic       clk_tx,
    input  logic       reset_tx,
    input  logic       sync,
    input  logic       pause,
    input  logic       pulse,
    input  logic       idle,
    input  logic [3:0] data_nibble,
    input  logic [9:0] pause_len,
    output logic       sent_out,
    output logic       pulse_done,
    output logic       busy,
    output logic       cmd_err
);
    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
    localparam logic [9:0] LOW_LAST = 10'(LOW_TICKS - 1);
    localparam logic [9:0] SYNC_LEN = 10'(SYNC_TICKS);
    localparam logic [9:0] NIB_LEN  = 10'(NIB_BASE);
    localparam logic [9:0] P_MIN    = 10'(PAUSE_MIN);
    localparam logic [9:0] P_MAX    = 10'(PAUSE_MAX);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t     state_q;
    logic [7:0] div_q;
    logic [9:0] tick_q;
    logic [9:0] len_q;
    logic       sent_q;
    logic       done_q;
    logic       busy_q;
    logic       err_q;

    logic       tick_end;
    logic       cmd_any;
    logic       sample;
    logic       period_end;
    logic       cmd_bad;
    logic [9:0] tick_inc;
    logic [9:0] pause_clamp;
    logic [9:0] len_d;

    assign tick_end    = div_q == DIV_LAST;
    assign cmd_any     = (sync | pause | pulse) & ~idle;
    assign tick_inc    = tick_q + 10'd1;
    assign sample      = state_q == LOW && tick_end && tick_q == LOW_LAST;
    assign period_end  = state_q == HIGH && tick_end && tick_q == len_q - 10'd1;
    assign cmd_bad     = ~((sync ^ pause ^ pulse) & ~(sync & pause & pulse));
    assign pause_clamp = pause_len < P_MIN ? P_MIN : pause_len > P_MAX ? P_MAX : pause_len;
    assign len_d       = sync ? SYNC_LEN : pause ? pause_clamp : pulse ? NIB_LEN + {6'd0, data_nibble} : NIB_LEN;

    assign sent_out   = sent_q;
    assign pulse_done = done_q;
    assign busy       = busy_q;
    assign cmd_err    = err_q;

    // Period FSM: prescaler, tick counter, command sampling and registered line outputs
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            tick_q  <= 10'd0;
            len_q   <= 10'd0;
            sent_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            div_q  <= tick_end ? 8'd0 : div_q + 8'd1;
            tick_q <= tick_end ? tick_inc : tick_q;
            case (state_q)
                IDLE: begin
                    div_q  <= 8'd0;
                    tick_q <= 10'd0;
                    if (cmd_any) begin
                        state_q <= LOW;
                        sent_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOW: begin
                    if (sample) begin
                        state_q <= HIGH;
                        len_q   <= len_d;
                        err_q   <= cmd_bad;
                        sent_q  <= 1'b1;
                        done_q  <= tick_inc == len_d - 10'd1;
                    end
                end
                HIGH: begin
                    if (period_end) begin
                        done_q <= 1'b0;
                        div_q  <= 8'd0;
                        tick_q <= 10'd0;
                        if (cmd_any) begin
                            state_q <= LOW;
                            sent_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (tick_end && tick_inc == len_q - 10'd1) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
